button_array_debouncer: RTL and testbench
=========================================

# button_array_debouncer

Multi-channel debouncer for the board push-buttons. It synchronises N raw active-low button inputs and debounces each channel independently. Each channel produces a level, a press pulse, a release pulse and an optional auto-repeat pulse. A lowest-index-wins encoder reduces all press and repeat pulses to a single key event per cycle, which the game control FSM uses as its move command.

## Interface
- N, 4, number of button channels; legal range 2..16.
- DB_CYCLES, 65535, consecutive cycles a new synchronised level must persist before it is accepted; legal range 2..2^20.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 holds repeat_o at 0.
- REPEAT_DELAY, 25000000, cycles from press pulse to first repeat pulse; must be ≥ 2.
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses; must be ≥ 2.
- Derived widths: DBW = $clog2(DB_CYCLES); RPW = $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)); CW = $clog2(N).

Ports:
- clk_i  in  1  system clock; single clock domain. All logic is on posedge clk_i.
- rst_i  in  1  synchronous, active-high reset.
- sw_i  in  N  raw buttons, asynchronous; 0 = pressed.
- sw_state_o  out  N  debounced level; 1 = pressed.
- sw_down_o  out  N  one-cycle pulse per accepted press.
- sw_up_o  out  N  one-cycle pulse per accepted release.
- sw_repeat_o  out  N  one-cycle auto-repeat pulse while held.
- event_valid_o  out  1  one-cycle pulse: a key event is present.
- event_code_o  out  CW  channel index of the event.
- event_repeat_o  out  1  1 = event came from a repeat pulse, 0 = from a press pulse.

## Operation
- Synchroniser: per channel, 2-flop chain capturing ~sw_i. Both flops reset to 0 (released).
- Debounce counter:
  - Each channel has a DBW-bit counter.
  - While the synchronised level ≠ sw_state_o, the counter increments each cycle.
  - When the levels are equal, the counter clears to 0.
  - At the edge where the counter equals DB_CYCLES-1 and the mismatch still holds, the following happen together:
    - sw_state_o toggles.
    - The counter clears.
    - sw_down_o (new state 1) or sw_up_o (new state 0) asserts for exactly that one cycle.
- Glitch rejection: any mismatch lasting < DB_CYCLES cycles leaves sw_state_o unchanged and produces no pulse.
- Auto-repeat counter, per channel:
  - States: IDLE → DELAY → PERIOD → IDLE.
  - IDLE → DELAY: at the edge sw_down_o asserts; the RPW-bit repeat counter clears.
  - DELAY: the counter increments each cycle. At count REPEAT_DELAY-1, sw_repeat_o pulses, the counter clears, and the FSM goes to PERIOD.
  - PERIOD: the same behaviour using REPEAT_PERIOD-1; the FSM stays in PERIOD.
  - Any state → IDLE: at the edge sw_up_o asserts; the counter clears.
  - A repeat pulse never coincides with a press or release pulse on the same channel.
  - REPEAT_EN=0: the FSM stays in IDLE.
- Event encoder:
  - Registered; looks at hits = sw_down_o | sw_repeat_o.
  - If hits ≠ 0, on the next edge:
    - event_valid_o = 1.
    - event_code_o = index of the lowest set bit.
    - event_repeat_o = sw_repeat_o[that index].
  - Higher-index simultaneous hits are dropped, not queued.
  - If hits = 0, event_valid_o = 0 and code/repeat hold their last value.
- Arithmetic: all counters are unsigned and never wrap, because they clear at their terminal count.

## Timing
- Reset (synchronous, any cycle, overrides everything): all outputs 0, all counters 0, synchroniser 0, repeat FSMs IDLE.
- Reset mid-count discards a pending press. After reset, a button already held is re-detected after the full latency and produces a fresh sw_down_o.
- Press/release latency: a new sw_i level first sampled at edge E appears on sw_state_o/sw_down_o after edge E+DB_CYCLES+1, provided the level is stable throughout.
- Event latency: event_valid_o follows sw_down_o/sw_repeat_o by exactly 1 cycle.
- Repeat timing: first sw_repeat_o comes REPEAT_DELAY cycles after sw_down_o, then one every REPEAT_PERIOD cycles, until the release is accepted.
- A release that is still bouncing does not stop repeats until the release is accepted.
- Channels are fully independent. Simultaneous presses on several channels give simultaneous sw_down_o bits.

## Test plan
Scenarios use N=4, DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, REPEAT_EN=1 unless stated.
- Clean press: sw_i[1] driven 1→0 before edge 10 and held → sw_state_o[1]=1 and sw_down_o=4'b0010 after edge 15 only. Then event_valid_o=1, event_code_o=1, event_repeat_o=0 after edge 16.
- Bounce: sw_i[0] toggles 0/1/0 with each level held 3 cycles, then settles at 0 → no pulse during bouncing; a single sw_down_o[0] 5 edges after the last transition is sampled.
- Auto-repeat: hold sw_i[2]=0 for 60 cycles after acceptance → sw_repeat_o[2] pulses at +20, +28, +36, +44, +52 cycles after sw_down_o[2]. Release → sw_up_o[2] pulse and no further repeats.
- Simultaneous: sw_i[3] and sw_i[1] pressed in the same cycle → sw_down_o=4'b1010; a single event with event_code_o=1.
- Reset mid-debounce: sw_i[0] held pressed; rst_i high for 1 cycle two cycles before acceptance → no pulse at the old acceptance time; sw_down_o[0] fires 5 edges after reset release. All outputs read 0 during reset.
- REPEAT_EN=0: hold sw_i[0] for 100 cycles → sw_repeat_o stays 0 throughout; exactly one event.

Source files
------------

// File: rtl/button_array_debouncer.sv
// Multi-channel push-button debouncer: per-channel synchroniser, debounce counter and
// auto-repeat FSM, plus a registered lowest-index-wins key event encoder.
module button_array_debouncer #(
  parameter int unsigned N             = 4,
  parameter int unsigned DB_CYCLES     = 65535,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 10000000,
  localparam int unsigned CW           = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  sw_i,
  output logic [N-1:0]  sw_state_o,
  output logic [N-1:0]  sw_down_o,
  output logic [N-1:0]  sw_up_o,
  output logic [N-1:0]  sw_repeat_o,
  output logic          event_valid_o,
  output logic [CW-1:0] event_code_o,
  output logic          event_repeat_o
);

  localparam int unsigned DBW  = $clog2(DB_CYCLES);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPW  = $clog2(RMAX);

  localparam logic [DBW-1:0] DbLast     = DBW'(DB_CYCLES - 1);
  localparam logic [RPW-1:0] DelayLast  = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] PeriodLast = RPW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StPeriod} rep_st_e;

  logic [N-1:0]   sync1_q, sync2_q;
  logic [N-1:0]   state_q, state_d;
  logic [N-1:0]   down_q, down_d;
  logic [N-1:0]   up_q, up_d;
  logic [N-1:0]   rep_q, rep_d;
  logic [DBW-1:0] db_cnt_q [N];
  logic [DBW-1:0] db_cnt_d [N];
  logic [RPW-1:0] rep_cnt_q [N];
  logic [RPW-1:0] rep_cnt_d [N];
  rep_st_e        rep_st_q [N];
  rep_st_e        rep_st_d [N];

  logic [N-1:0]   hits;
  logic           ev_valid_q, ev_valid_d;
  logic [CW-1:0]  ev_code_q, ev_code_d;
  logic           ev_rep_q, ev_rep_d;

  // Inputs are active-low; the synchroniser stores the pressed level as 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~sw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive mismatch cycles, accept at the terminal count.
  always_comb begin
    state_d  = state_q;
    down_d   = '0;
    up_d     = '0;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < int'(N); i++) begin
      if (sync2_q[i] != state_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          db_cnt_d[i] = '0;
          state_d[i]  = ~state_q[i];
          down_d[i]   = ~state_q[i];
          up_d[i]     = state_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= '0;
      down_q  <= '0;
      up_q    <= '0;
      for (int i = 0; i < int'(N); i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      down_q   <= down_d;
      up_q     <= up_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Auto-repeat FSM; an accepted release takes priority so it never shares a cycle
  // with a repeat pulse.
  always_comb begin
    rep_st_d  = rep_st_q;
    rep_cnt_d = rep_cnt_q;
    rep_d     = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (up_d[i]) begin
        rep_st_d[i]  = StIdle;
        rep_cnt_d[i] = '0;
      end else if (down_d[i] && REPEAT_EN) begin
        rep_st_d[i]  = StDelay;
        rep_cnt_d[i] = '0;
      end else begin
        case (rep_st_q[i])
          StDelay: begin
            if (rep_cnt_q[i] == DelayLast) begin
              rep_d[i]     = 1'b1;
              rep_cnt_d[i] = '0;
              rep_st_d[i]  = StPeriod;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
            end
          end
          StPeriod: begin
            if (rep_cnt_q[i] == PeriodLast) begin
              rep_d[i]     = 1'b1;
              rep_cnt_d[i] = '0;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
            end
          end
          default: begin
            rep_st_d[i]  = StIdle;
            rep_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rep_q <= '0;
      for (int i = 0; i < int'(N); i++) begin
        rep_st_q[i]  <= StIdle;
        rep_cnt_q[i] <= '0;
      end
    end else begin
      rep_q     <= rep_d;
      rep_st_q  <= rep_st_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  // Lowest index wins; higher simultaneous hits are dropped.
  always_comb begin
    hits       = down_q | rep_q;
    ev_valid_d = |hits;
    ev_code_d  = ev_code_q;
    ev_rep_d   = ev_rep_q;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (hits[i]) begin
        ev_code_d = CW'(i);
        ev_rep_d  = rep_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ev_valid_q <= 1'b0;
      ev_code_q  <= '0;
      ev_rep_q   <= 1'b0;
    end else begin
      ev_valid_q <= ev_valid_d;
      ev_code_q  <= ev_code_d;
      ev_rep_q   <= ev_rep_d;
    end
  end

  assign sw_state_o     = state_q;
  assign sw_down_o      = down_q;
  assign sw_up_o        = up_q;
  assign sw_repeat_o    = rep_q;
  assign event_valid_o  = ev_valid_q;
  assign event_code_o   = ev_code_q;
  assign event_repeat_o = ev_rep_q;

endmodule

// File: tb/tb_button_array_debouncer.sv
// Bench for button_array_debouncer: scoreboard of expected pulses checked every cycle,
// a table of press vectors, and hand-written multi-cycle sequences.
module tb_button_array_debouncer;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw  = '1;
  logic [N-1:0] sw2 = '1;

  logic [N-1:0] sw_state_o, sw_down_o, sw_up_o, sw_repeat_o;
  logic         event_valid_o, event_repeat_o;
  logic [1:0]   event_code_o;

  logic [N-1:0] d2_state, d2_down, d2_up, d2_rep;
  logic         d2_ev_valid, d2_ev_rep;
  logic [1:0]   d2_ev_code;

  button_array_debouncer #(
    .N(4), .DB_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sw_i(sw),
    .sw_state_o(sw_state_o), .sw_down_o(sw_down_o), .sw_up_o(sw_up_o),
    .sw_repeat_o(sw_repeat_o), .event_valid_o(event_valid_o),
    .event_code_o(event_code_o), .event_repeat_o(event_repeat_o)
  );

  button_array_debouncer #(
    .N(4), .DB_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut_norep (
    .clk_i(clk), .rst_i(rst), .sw_i(sw2),
    .sw_state_o(d2_state), .sw_down_o(d2_down), .sw_up_o(d2_up),
    .sw_repeat_o(d2_rep), .event_valid_o(d2_ev_valid),
    .event_code_o(d2_ev_code), .event_repeat_o(d2_ev_rep)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int         t;
    logic [3:0] down;
    logic [3:0] up;
    logic [3:0] rep;
  } exp_t;
  exp_t sbq[$];

  task automatic push(input int t, input logic [3:0] d, input logic [3:0] u,
                      input logic [3:0] r);
    exp_t e;
    e.t = t; e.down = d; e.up = u; e.rep = r;
    sbq.push_back(e);
  endtask

  // Monitor: pops this cycle's expected pulses and checks every output mid-cycle.
  logic [3:0] e_down, e_up, e_rep, exp_state, prev_hits, prev_rep;
  logic [1:0] held_code;
  logic       held_rep, ev_exp;
  initial begin
    exp_state = '0; prev_hits = '0; prev_rep = '0; held_code = '0; held_rep = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        if (rst_seen) begin
          check("rst_state", 32'(sw_state_o), 32'(0));
          check("rst_down", 32'(sw_down_o), 32'(0));
          check("rst_up", 32'(sw_up_o), 32'(0));
          check("rst_rep", 32'(sw_repeat_o), 32'(0));
          check("rst_ev_valid", 32'(event_valid_o), 32'(0));
          check("rst_ev_code", 32'(event_code_o), 32'(0));
          check("rst_ev_rep", 32'(event_repeat_o), 32'(0));
          exp_state = '0; prev_hits = '0; prev_rep = '0; held_code = '0; held_rep = 1'b0;
        end else begin
          e_down = '0; e_up = '0; e_rep = '0;
          for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].t == cyc) begin
              e_down |= sbq[k].down;
              e_up   |= sbq[k].up;
              e_rep  |= sbq[k].rep;
              sbq.delete(k);
            end
          end
          check("down", 32'(sw_down_o), 32'(e_down));
          check("up", 32'(sw_up_o), 32'(e_up));
          check("repeat", 32'(sw_repeat_o), 32'(e_rep));
          exp_state = (exp_state | e_down) & ~e_up;
          check("state", 32'(sw_state_o), 32'(exp_state));
          ev_exp = |prev_hits;
          for (int b = 3; b >= 0; b--) begin
            if (prev_hits[b]) begin
              held_code = 2'(b);
              held_rep  = prev_rep[b];
            end
          end
          check("ev_valid", 32'(event_valid_o), 32'(ev_exp));
          check("ev_code", 32'(event_code_o), 32'(held_code));
          check("ev_rep", 32'(event_repeat_o), 32'(held_rep));
          prev_hits = e_down | e_rep;
          prev_rep  = e_rep;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] mask;
    logic [3:0] exp_down;
    int         exp_code;
  } vec_t;
  vec_t vecs[5];

  int t0, d, n_rep, n_ev, n_dn, last_code;

  initial begin
    vecs[0] = '{mask: 4'b0010, exp_down: 4'b0010, exp_code: 1};
    vecs[1] = '{mask: 4'b1010, exp_down: 4'b1010, exp_code: 1};
    vecs[2] = '{mask: 4'b1111, exp_down: 4'b1111, exp_code: 0};
    vecs[3] = '{mask: 4'b1000, exp_down: 4'b1000, exp_code: 3};
    vecs[4] = '{mask: 4'b0100, exp_down: 4'b0100, exp_code: 2};

    goto(3);
    rst = 1'b0;
    goto(5);

    // Clean presses, including simultaneous ones; short holds give no repeats.
    for (int v = 0; v < 5; v++) begin
      t0 = cyc;
      sw = ~vecs[v].mask;
      push(t0 + 6, vecs[v].exp_down, 4'b0, 4'b0);
      goto(t0 + 7);
      check("tbl_ev_valid", 32'(event_valid_o), 32'(1));
      check("tbl_ev_code", 32'(event_code_o), 32'(vecs[v].exp_code));
      check("tbl_ev_rep", 32'(event_repeat_o), 32'(0));
      goto(t0 + 10);
      sw = '1;
      push(t0 + 16, 4'b0, vecs[v].exp_down, 4'b0);
      goto(t0 + 24);
    end

    // Bouncing press: two 3-cycle glitches are rejected, the final level is accepted.
    t0 = cyc;
    sw[0] = 1'b0;
    goto(t0 + 3);
    sw[0] = 1'b1;
    goto(t0 + 6);
    sw[0] = 1'b0;
    push(t0 + 12, 4'b0001, 4'b0, 4'b0);
    goto(t0 + 22);
    sw[0] = 1'b1;
    push(t0 + 28, 4'b0, 4'b0001, 4'b0);
    goto(t0 + 36);

    // Long hold on channel 2: repeats at +20 then every 8 until the release.
    t0 = cyc;
    d  = t0 + 6;
    sw[2] = 1'b0;
    push(d, 4'b0100, 4'b0, 4'b0);
    for (int j = 0; j < 5; j++) push(d + 20 + 8 * j, 4'b0, 4'b0, 4'b0100);
    goto(d + 53);
    sw[2] = 1'b1;
    push(d + 59, 4'b0, 4'b0100, 4'b0);
    goto(d + 70);

    // Release accepted exactly when the first repeat would fire: no repeat.
    t0 = cyc;
    d  = t0 + 6;
    sw[3] = 1'b0;
    push(d, 4'b1000, 4'b0, 4'b0);
    goto(d + 14);
    sw[3] = 1'b1;
    push(d + 20, 4'b0, 4'b1000, 4'b0);
    goto(d + 30);

    // Bouncing release keeps repeating; final release suppresses the +28 repeat.
    t0 = cyc;
    d  = t0 + 6;
    sw[1] = 1'b0;
    push(d, 4'b0010, 4'b0, 4'b0);
    push(d + 20, 4'b0, 4'b0, 4'b0010);
    goto(d + 17);
    sw[1] = 1'b1;
    goto(d + 19);
    sw[1] = 1'b0;
    goto(d + 22);
    sw[1] = 1'b1;
    push(d + 28, 4'b0, 4'b0010, 4'b0);
    goto(d + 36);

    // Reset two cycles before acceptance discards the pending press.
    t0 = cyc;
    sw[0] = 1'b0;
    goto(t0 + 3);
    rst = 1'b1;
    goto(t0 + 4);
    rst = 1'b0;
    push(t0 + 10, 4'b0001, 4'b0, 4'b0);
    goto(t0 + 20);
    sw[0] = 1'b1;
    push(t0 + 26, 4'b0, 4'b0001, 4'b0);
    goto(t0 + 34);

    // Auto-repeat disabled: a 100+ cycle hold yields one press and one event only.
    t0 = cyc;
    sw2[0] = 1'b0;
    n_rep = 0; n_ev = 0; n_dn = 0; last_code = -1;
    for (int k = 0; k < 106; k++) begin
      goto(cyc + 1);
      n_rep += $countones(d2_rep);
      n_dn  += $countones(d2_down);
      if (d2_ev_valid) begin
        n_ev++;
        last_code = int'(d2_ev_code);
      end
    end
    check("norep_repeats", 32'(n_rep), 32'(0));
    check("norep_downs", 32'(n_dn), 32'(1));
    check("norep_events", 32'(n_ev), 32'(1));
    check("norep_code", 32'(last_code), 32'(0));
    check("norep_state", 32'(d2_state), 32'(4'b0001));
    sw2[0] = 1'b1;
    goto(cyc + 10);
    check("norep_released", 32'(d2_state), 32'(0));

    goto(cyc + 2);
    check("sb_empty", 32'(sbq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
